// File: rtl/pc_ctrl_if.sv
// pc_ctrl_if: request and fetch-address bundle between the IF stage and pc_ctrl.
// master drives the requests and reads the fetch outputs; slave is pc_ctrl itself.
interface pc_ctrl_if #(
  parameter int unsigned XLEN = 32
);
  logic            Stall;
  logic            BranchTaken;
  logic [XLEN-1:0] BranchTarget;
  logic            TrapReq;
  logic [XLEN-1:0] TrapVector;
  logic            HaltReq;
  logic            Resume;
`ifdef PC_CTRL_COMPRESSED_EN
  logic            Is16;
`endif
  logic [XLEN-1:0] PCOutput;
  logic [XLEN-1:0] PCPlus4;
  logic            FetchValid;
  logic            MisalignFault;
  logic [XLEN-1:0] FaultAddr;

  modport master (
`ifdef PC_CTRL_COMPRESSED_EN
    output Is16,
`endif
    output Stall, BranchTaken, BranchTarget,
    output TrapReq, TrapVector, HaltReq, Resume,
    input  PCOutput, PCPlus4, FetchValid,
    input  MisalignFault, FaultAddr
  );

  modport slave (
`ifdef PC_CTRL_COMPRESSED_EN
    input  Is16,
`endif
    input  Stall, BranchTaken, BranchTarget,
    input  TrapReq, TrapVector, HaltReq, Resume,
    output PCOutput, PCPlus4, FetchValid,
    output MisalignFault, FaultAddr
  );
endinterface

// File: rtl/pc_ctrl.sv
// pc_ctrl: fetch PC register with trap/branch/stall arbitration, boot delay and halt.
// Ports: clk, reset (sync, active-high), bus (pc_ctrl_if.slave). Option macro: PC_CTRL_COMPRESSED_EN.
module pc_ctrl #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     BOOT_CYCLES  = 4
) (
  input logic     clk,
  input logic     reset,
  pc_ctrl_if.slave bus
);

  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  localparam int CW =
    (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES + 1) : 1;

`ifdef PC_CTRL_COMPRESSED_EN
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(1);
`else
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(3);
`endif

  logic [1:0]      state;
  logic [CW-1:0]   boot_cnt;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pc_seq;
  logic [XLEN-1:0] trap_tgt;
  logic            br_misaligned;
  logic            fault_q;
  logic [XLEN-1:0] fault_addr_q;

  assign pc_plus4 = pc + XLEN'(4);

`ifdef PC_CTRL_COMPRESSED_EN
  assign pc_seq = bus.Is16 ? pc + XLEN'(2) : pc_plus4;
`else
  assign pc_seq = pc_plus4;
`endif

  assign trap_tgt      = bus.TrapVector & ~ALIGN_MASK;
  assign br_misaligned = |(bus.BranchTarget & ALIGN_MASK);

  assign bus.PCOutput      = pc;
  assign bus.PCPlus4       = pc_plus4;
  assign bus.FetchValid    = (state == S_RUN);
  assign bus.MisalignFault = fault_q;
  assign bus.FaultAddr     = fault_addr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc           <= RESET_VECTOR;
      boot_cnt     <= CW'(BOOT_CYCLES);
      state        <= (BOOT_CYCLES == 0) ? S_RUN : S_BOOT;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      fault_q <= 1'b0;
      unique case (state)
        S_BOOT: begin
          if (boot_cnt <= CW'(1)) begin
            state <= S_RUN;
          end else begin
            boot_cnt <= boot_cnt - CW'(1);
          end
        end
        S_RUN: begin
          // A redirect always lands; halt may join it on the same edge.
          if (bus.TrapReq) begin
            pc <= trap_tgt;
          end else if (bus.BranchTaken) begin
            if (br_misaligned) begin
              pc           <= pc_plus4;
              fault_q      <= 1'b1;
              fault_addr_q <= bus.BranchTarget;
            end else begin
              pc <= bus.BranchTarget;
            end
          end else if (!bus.HaltReq && !bus.Stall) begin
            pc <= pc_seq;
          end
          if (bus.HaltReq) begin
            state <= S_HALT;
          end
        end
        S_HALT: begin
          if (bus.TrapReq) begin
            pc    <= trap_tgt;
            state <= S_RUN;
          end else if (bus.Resume) begin
            state <= S_RUN;
          end
        end
        default: state <= S_BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl: directed scenario bench for pc_ctrl.
// RESET_VECTOR=0x100, BOOT_CYCLES=4; one task per scenario.
module tb_pc_ctrl;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  pc_ctrl_if #(.XLEN(32)) bus ();

  pc_ctrl #(
    .XLEN(32),
    .RESET_VECTOR(32'h100),
    .BOOT_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.Stall = 0; bus.BranchTaken = 0; bus.BranchTarget = 0;
    bus.TrapReq = 0; bus.TrapVector = 0; bus.HaltReq = 0; bus.Resume = 0;
`ifdef PC_CTRL_COMPRESSED_EN
    bus.Is16 = 0;
`endif
  endtask

  task automatic jump(input logic [31:0] a);
    bus.TrapReq = 1; bus.TrapVector = a;
    step();
    bus.TrapReq = 0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    step();
    total++; if (bus.PCOutput !== 32'h100) begin bad++; $display("FAIL rst_pc got=%h exp=%h", bus.PCOutput, 32'h100); end
    total++; if (bus.FetchValid !== 1'b0) begin bad++; $display("FAIL rst_fv got=%b exp=0", bus.FetchValid); end
    total++; if (bus.MisalignFault !== 1'b0) begin bad++; $display("FAIL rst_mf got=%b exp=0", bus.MisalignFault); end
    total++; if (bus.FaultAddr !== 32'h0) begin bad++; $display("FAIL rst_fa got=%h exp=0", bus.FaultAddr); end
    reset = 0;
    // requests during boot must be ignored
    bus.BranchTaken = 1; bus.BranchTarget = 32'h300; bus.TrapReq = 1; bus.TrapVector = 32'h500;
    for (int i = 0; i < 4; i++) begin
      total++; if (bus.FetchValid !== 1'b0) begin bad++; $display("FAIL boot_fv%0d got=%b exp=0", i, bus.FetchValid); end
      total++; if (bus.PCOutput !== 32'h100) begin bad++; $display("FAIL boot_pc%0d got=%h exp=%h", i, bus.PCOutput, 32'h100); end
      step();
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      total++; if (bus.FetchValid !== 1'b1) begin bad++; $display("FAIL run_fv%0d got=%b exp=1", i, bus.FetchValid); end
      total++; if (bus.PCOutput !== 32'h100 + 32'(4 * i)) begin bad++; $display("FAIL run_pc%0d got=%h exp=%h", i, bus.PCOutput, 32'h100 + 32'(4 * i)); end
      step();
    end
  endtask

  task automatic test_stall_branch();
    jump(32'h200);
    total++; if (bus.PCOutput !== 32'h200) begin bad++; $display("FAIL sb_start got=%h exp=%h", bus.PCOutput, 32'h200); end
    bus.Stall = 1;
    step();
    total++; if (bus.PCOutput !== 32'h200) begin bad++; $display("FAIL sb_hold got=%h exp=%h", bus.PCOutput, 32'h200); end
    bus.BranchTaken = 1; bus.BranchTarget = 32'h400;
    step();
    bus.BranchTaken = 0;
    total++; if (bus.PCOutput !== 32'h400) begin bad++; $display("FAIL sb_redir got=%h exp=%h", bus.PCOutput, 32'h400); end
    step();
    total++; if (bus.PCOutput !== 32'h400) begin bad++; $display("FAIL sb_hold2 got=%h exp=%h", bus.PCOutput, 32'h400); end
    bus.Stall = 0;
    step();
    total++; if (bus.PCOutput !== 32'h404) begin bad++; $display("FAIL sb_adv got=%h exp=%h", bus.PCOutput, 32'h404); end
  endtask

  task automatic test_trap_branch();
    bus.TrapReq = 1; bus.TrapVector = 32'h803;
    bus.BranchTaken = 1; bus.BranchTarget = 32'h500;
    step();
    idle();
    total++; if (bus.PCOutput !== 32'h800) begin bad++; $display("FAIL tb_pc got=%h exp=%h", bus.PCOutput, 32'h800); end
    total++; if (bus.MisalignFault !== 1'b0) begin bad++; $display("FAIL tb_mf got=%b exp=0", bus.MisalignFault); end
  endtask

  task automatic test_misalign();
    jump(32'h40);
    bus.BranchTaken = 1; bus.BranchTarget = 32'h1002;
    step();
    bus.BranchTaken = 0;
    total++; if (bus.PCOutput !== 32'h44) begin bad++; $display("FAIL ma_pc got=%h exp=%h", bus.PCOutput, 32'h44); end
    total++; if (bus.MisalignFault !== 1'b1) begin bad++; $display("FAIL ma_mf got=%b exp=1", bus.MisalignFault); end
    total++; if (bus.FaultAddr !== 32'h1002) begin bad++; $display("FAIL ma_fa got=%h exp=%h", bus.FaultAddr, 32'h1002); end
    step();
    total++; if (bus.PCOutput !== 32'h48) begin bad++; $display("FAIL ma_pc2 got=%h exp=%h", bus.PCOutput, 32'h48); end
    total++; if (bus.MisalignFault !== 1'b0) begin bad++; $display("FAIL ma_mf2 got=%b exp=0", bus.MisalignFault); end
    total++; if (bus.FaultAddr !== 32'h1002) begin bad++; $display("FAIL ma_fa2 got=%h exp=%h", bus.FaultAddr, 32'h1002); end
  endtask

  task automatic test_back_to_back();
    bus.BranchTaken = 1; bus.BranchTarget = 32'h2001;
    step();
    total++; if (bus.MisalignFault !== 1'b1) begin bad++; $display("FAIL bb_mf1 got=%b exp=1", bus.MisalignFault); end
    total++; if (bus.FaultAddr !== 32'h2001) begin bad++; $display("FAIL bb_fa1 got=%h exp=%h", bus.FaultAddr, 32'h2001); end
    total++; if (bus.PCOutput !== 32'h4c) begin bad++; $display("FAIL bb_pc1 got=%h exp=%h", bus.PCOutput, 32'h4c); end
    bus.BranchTarget = 32'h3003;
    step();
    bus.BranchTaken = 0;
    total++; if (bus.MisalignFault !== 1'b1) begin bad++; $display("FAIL bb_mf2 got=%b exp=1", bus.MisalignFault); end
    total++; if (bus.FaultAddr !== 32'h3003) begin bad++; $display("FAIL bb_fa2 got=%h exp=%h", bus.FaultAddr, 32'h3003); end
    total++; if (bus.PCOutput !== 32'h50) begin bad++; $display("FAIL bb_pc2 got=%h exp=%h", bus.PCOutput, 32'h50); end
    step();
    total++; if (bus.MisalignFault !== 1'b0) begin bad++; $display("FAIL bb_mf3 got=%b exp=0", bus.MisalignFault); end
    total++; if (bus.PCOutput !== 32'h54) begin bad++; $display("FAIL bb_pc3 got=%h exp=%h", bus.PCOutput, 32'h54); end
  endtask

  task automatic test_halt();
    jump(32'h60);
    bus.HaltReq = 1;
    step();
    bus.HaltReq = 0;
    total++; if (bus.FetchValid !== 1'b0) begin bad++; $display("FAIL h_fv got=%b exp=0", bus.FetchValid); end
    total++; if (bus.PCOutput !== 32'h60) begin bad++; $display("FAIL h_pc got=%h exp=%h", bus.PCOutput, 32'h60); end
    bus.BranchTaken = 1; bus.BranchTarget = 32'h700;
    step();
    bus.BranchTaken = 0;
    total++; if (bus.PCOutput !== 32'h60) begin bad++; $display("FAIL h_ign got=%h exp=%h", bus.PCOutput, 32'h60); end
    total++; if (bus.FetchValid !== 1'b0) begin bad++; $display("FAIL h_ign_fv got=%b exp=0", bus.FetchValid); end
    bus.Resume = 1;
    step();
    bus.Resume = 0;
    total++; if (bus.FetchValid !== 1'b1) begin bad++; $display("FAIL h_res_fv got=%b exp=1", bus.FetchValid); end
    total++; if (bus.PCOutput !== 32'h60) begin bad++; $display("FAIL h_res_pc got=%h exp=%h", bus.PCOutput, 32'h60); end
    step();
    total++; if (bus.PCOutput !== 32'h64) begin bad++; $display("FAIL h_next got=%h exp=%h", bus.PCOutput, 32'h64); end
    bus.HaltReq = 1;
    step();
    bus.HaltReq = 0;
    bus.TrapReq = 1; bus.TrapVector = 32'h900; bus.Resume = 1;
    step();
    idle();
    total++; if (bus.PCOutput !== 32'h900) begin bad++; $display("FAIL h_trap_pc got=%h exp=%h", bus.PCOutput, 32'h900); end
    total++; if (bus.FetchValid !== 1'b1) begin bad++; $display("FAIL h_trap_fv got=%b exp=1", bus.FetchValid); end
    step();
    total++; if (bus.PCOutput !== 32'h904) begin bad++; $display("FAIL h_trap_next got=%h exp=%h", bus.PCOutput, 32'h904); end
    bus.HaltReq = 1; bus.BranchTaken = 1; bus.BranchTarget = 32'ha00;
    step();
    idle();
    total++; if (bus.PCOutput !== 32'ha00) begin bad++; $display("FAIL hb_pc got=%h exp=%h", bus.PCOutput, 32'ha00); end
    total++; if (bus.FetchValid !== 1'b0) begin bad++; $display("FAIL hb_fv got=%b exp=0", bus.FetchValid); end
    bus.Resume = 1;
    step();
    bus.Resume = 0;
    total++; if (bus.FetchValid !== 1'b1) begin bad++; $display("FAIL hb_res got=%b exp=1", bus.FetchValid); end
  endtask

  task automatic test_wrap();
    jump(32'hffff_fffc);
    total++; if (bus.PCOutput !== 32'hffff_fffc) begin bad++; $display("FAIL w_pc got=%h exp=fffffffc", bus.PCOutput); end
    total++; if (bus.PCPlus4 !== 32'h0) begin bad++; $display("FAIL w_p4 got=%h exp=0", bus.PCPlus4); end
    step();
    total++; if (bus.PCOutput !== 32'h0) begin bad++; $display("FAIL w_next got=%h exp=0", bus.PCOutput); end
  endtask

  task automatic test_reset_mid();
    bus.Stall = 1;
    step();
    reset = 1;
    step();
    reset = 0;
    idle();
    total++; if (bus.PCOutput !== 32'h100) begin bad++; $display("FAIL rs_pc got=%h exp=%h", bus.PCOutput, 32'h100); end
    total++; if (bus.FetchValid !== 1'b0) begin bad++; $display("FAIL rs_fv got=%b exp=0", bus.FetchValid); end
    bus.HaltReq = 1;
    repeat (4) step();
    bus.HaltReq = 0;
    step();
    bus.HaltReq = 1;
    step();
    bus.HaltReq = 0;
    total++; if (bus.FetchValid !== 1'b0) begin bad++; $display("FAIL rh_pre got=%b exp=0", bus.FetchValid); end
    reset = 1;
    step();
    reset = 0;
    total++; if (bus.PCOutput !== 32'h100) begin bad++; $display("FAIL rh_pc got=%h exp=%h", bus.PCOutput, 32'h100); end
    total++; if (bus.FetchValid !== 1'b0) begin bad++; $display("FAIL rh_fv got=%b exp=0", bus.FetchValid); end
    repeat (4) step();
    total++; if (bus.FetchValid !== 1'b1) begin bad++; $display("FAIL rh_boot got=%b exp=1", bus.FetchValid); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1;
    idle();
    test_reset();
    test_stall_branch();
    test_trap_branch();
    test_misalign();
    test_back_to_back();
    test_halt();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
- Parametrised program-counter controller for the pipelined RV32I core. It replaces the plain PC register at the head of the IF stage.
- Holds the fetch address and computes the sequential increment internally.
- Arbitrates trap, branch and stall requests; runs a boot-delay and halt state machine; flags misaligned redirect targets.
- Outputs feed instruction memory and the IF/ID pipeline register.

Parameters:
- XLEN, 32, width of PC and all address ports
- RESET_VECTOR, 32'h00000000, PC value loaded on reset
- BOOT_CYCLES, 4, cycles after reset release before the first valid fetch (0 allowed)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- Stall  in  1  hold PC (IF/ID hazard stall)
- BranchTaken  in  1  redirect request from EX
- BranchTarget  in  XLEN  redirect address from EX
- TrapReq  in  1  trap redirect request from exception unit
- TrapVector  in  XLEN  trap handler address
- HaltReq  in  1  enter HALT at next update
- Resume  in  1  leave HALT
- PCOutput  out  XLEN  current fetch address
- PCPlus4  out  XLEN  PCOutput + 4, combinational, wraps modulo 2^XLEN
- FetchValid  out  1  PCOutput is a live fetch this cycle
- MisalignFault  out  1  one-cycle pulse: rejected misaligned redirect
- FaultAddr  out  XLEN  last rejected target; holds until next fault

Behaviour:
- Reset (sync, active-high, any state, overrides all inputs):
  - PCOutput=RESET_VECTOR, FetchValid=0, MisalignFault=0, FaultAddr=0.
  - Boot counter = BOOT_CYCLES; state=BOOT, or RUN if BOOT_CYCLES=0.
- States: BOOT, RUN, HALT.
- BOOT:
  - PC is held; all requests are ignored; FetchValid=0.
  - Counter decrements each cycle; on reaching 1 -> RUN.
  - First valid fetch of RESET_VECTOR occurs exactly BOOT_CYCLES cycles after reset deasserts.
- RUN (FetchValid=1). Next-PC priority, highest first:
  1. TrapReq: PC <= TrapVector. The low 2 bits are forced to 0; no fault is raised.
  2. BranchTaken: if BranchTarget[1:0]==0, PC <= BranchTarget. Otherwise PC <= PCPlus4, MisalignFault pulses next cycle and FaultAddr <= BranchTarget.
  3. HaltReq: state -> HALT; PC is held.
  4. Stall: PC is held.
  5. Otherwise: PC <= PCPlus4.
- Simultaneous events in RUN:
  - Trap and branch both take effect over Stall; the redirect is never lost to a stall.
  - HaltReq together with TrapReq or BranchTaken: the redirect loads first and HALT is entered the same edge. PC in HALT equals the redirect target.
- HALT:
  - FetchValid=0; PC is held; Stall and BranchTaken are ignored.
  - TrapReq loads TrapVector and returns to RUN.
  - Resume returns to RUN with the same PC.
  - TrapReq wins over Resume.
- Wrap-around: PC at 2^XLEN-4 with no redirect -> 0, silently.
- MisalignFault is exactly one cycle wide. A fault on consecutive cycles yields consecutive pulses, with FaultAddr updating each time.
- No combinational path from any request input to PCOutput. Latency from request to new PCOutput is exactly 1 cycle.

Optional Feature:
- Macro: PC_CTRL_COMPRESSED_EN.
- Defined:
  - Redirect alignment check uses only bit 0 (2-byte alignment); the trap vector forces only bit 0 to 0.
  - Adds input Is16, 1 bit. In RUN sequential advance, Is16=1 -> PC+2, else PC+4.
  - PCPlus4 port keeps its name and always gives PC+4.
- Undefined: the Is16 port does not exist; 4-byte alignment rules as above.

Test Plan:
- Reset, BOOT_CYCLES=4, RESET_VECTOR=0x100 -> FetchValid=0 for 4 cycles after reset drops, then PCOutput=0x100,0x104,0x108 with FetchValid=1.
- PC=0x200, Stall high 3 cycles with BranchTaken=1 to 0x400 in cycle 2 -> PC 0x200,0x200,0x400, then holds 0x400 while Stall remains high.
- TrapReq (TrapVector=0x803) and BranchTaken (0x500) in the same cycle -> PC=0x800, MisalignFault stays 0.
- BranchTaken to 0x1002 at PC=0x40 -> PC=0x44, MisalignFault=1 for one cycle, FaultAddr=0x1002 held afterward.
- HaltReq at PC=0x60 -> FetchValid=0, PC holds 0x60, BranchTaken ignored; Resume -> FetchValid=1, next PC 0x64. Separately, TrapReq during HALT -> PC=TrapVector, state RUN.
- PC=0xFFFFFFFC free-running -> next 0x00000000; reset asserted mid-stall/HALT -> PC=RESET_VECTOR, state BOOT, FetchValid=0 next cycle.
